// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider.
//   div_state_e  : FSM state encoding (IDLE, RUN, FIX, DONE)
//   cnt_width(n) : width of the RUN step counter, $clog2(n) but never below 1
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  function automatic int cnt_width(input int n);
    if ($clog2(n) < 1) return 1;
    else return $clog2(n);
  endfunction

endpackage

// File: rtl/seq_divider_rca.sv
// Ripple-carry adder used for the trial subtraction and the sign fix-ups.
//   W    : operand width
//   a    : addend A
//   b    : addend B
//   cin  : carry in
//   sum  : A + B + cin, truncated to W bits
module seq_divider_rca #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum
);

  logic [W:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (a[i] & carry[i]) | (b[i] & carry[i]);
  end

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider, one quotient bit per clock.
//   clk, rst     : clock, asynchronous active-high reset
//   start        : request, accepted only while busy=0
//   is_signed    : 1 = two's-complement operands/results
//   dividend     : numerator (sampled with start)
//   divisor      : denominator (sampled with start)
//   busy         : high while an operation is in flight, including the done cycle
//   done         : one-cycle pulse, results valid from this cycle on
//   quotient     : registered quotient (truncated toward zero)
//   remainder    : registered remainder (sign of the dividend)
//   div_by_zero  : registered flag for the last completed operation
//   dbg_state    : current FSM state, for observation only
//
// Handshake: start is a request sampled on a rising clk edge only when
// busy=0; operands are captured on that same edge. busy then stays high
// until the cycle after the done pulse, so any start seen while busy=1 is
// dropped without resampling operands.
//
// Timeline (edge 0 = accept): RUN steps on edges 1..N, results are
// registered on the FIX edge N+1, done is high for the cycle after edge
// N+2 and busy drops at edge N+3.
module seq_divider
  import div_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         is_signed,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero,
  output div_state_e   dbg_state
);

  localparam int CW = cnt_width(N);

  div_state_e    state;
  div_state_e    next_state;
  logic [CW-1:0] cnt;
  // Partial remainder. After every restoring step it is below the divisor
  // magnitude, so its top bit is zero and only N bits need storing; the
  // N+1-bit working value is formed by the shift below.
  logic [N-1:0]  r;
  logic [N-1:0]  q;
  logic [N-1:0]  dmag;
  logic [N-1:0]  dvd_raw;
  logic          q_neg;
  logic          r_neg;
  logic          dz;
  logic          done_q;

  logic          neg_dvd;
  logic          neg_dvs;
  logic          accept;
  logic [N-1:0]  dvd_mag;
  logic [N-1:0]  dvs_mag;
  logic [N:0]    r_sh;
  logic [N:0]    trial;
  logic [N-1:0]  q_fix;
  logic [N-1:0]  r_fix;

  assign neg_dvd = is_signed & dividend[N-1];
  assign neg_dvs = is_signed & divisor[N-1];
  assign accept  = (state == IDLE) && start && !done_q;

  // Operand magnitudes: XOR with the sign and carry it in.
  seq_divider_rca #(.W(N)) u_dvd_mag (
    .a   (dividend ^ {N{neg_dvd}}),
    .b   ({N{1'b0}}),
    .cin (neg_dvd),
    .sum (dvd_mag)
  );

  seq_divider_rca #(.W(N)) u_dvs_mag (
    .a   (divisor ^ {N{neg_dvs}}),
    .b   ({N{1'b0}}),
    .cin (neg_dvs),
    .sum (dvs_mag)
  );

  // Trial subtraction R - Dmag as R + ~Dmag + 1 at N+1 bits; a set MSB
  // means the subtraction went negative and R is kept.
  assign r_sh = {r, q[N-1]};

  seq_divider_rca #(.W(N+1)) u_trial (
    .a   (r_sh),
    .b   (~{1'b0, dmag}),
    .cin (1'b1),
    .sum (trial)
  );

  // Result sign fix-ups.
  seq_divider_rca #(.W(N)) u_q_fix (
    .a   (q ^ {N{q_neg}}),
    .b   ({N{1'b0}}),
    .cin (q_neg),
    .sum (q_fix)
  );

  seq_divider_rca #(.W(N)) u_r_fix (
    .a   (r ^ {N{r_neg}}),
    .b   ({N{1'b0}}),
    .cin (r_neg),
    .sum (r_fix)
  );

  // State, counter and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      r           <= '0;
      q           <= '0;
      dmag        <= '0;
      dvd_raw     <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      dz          <= 1'b0;
      done_q      <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state  <= next_state;
      // done trails entry into DONE by one cycle; busy covers that cycle.
      done_q <= (state == DONE);
      case (state)
        IDLE: begin
          if (accept) begin
            cnt     <= CW'(N - 1);
            r       <= '0;
            q       <= dvd_mag;
            dmag    <= dvs_mag;
            dvd_raw <= dividend;
            q_neg   <= neg_dvd ^ neg_dvs;
            r_neg   <= neg_dvd;
            dz      <= (divisor == '0);
          end
        end
        RUN: begin
          q   <= {q[N-2:0], ~trial[N]};
          r   <= trial[N] ? r_sh[N-1:0] : trial[N-1:0];
          cnt <= cnt - 1'b1;
        end
        FIX: begin
          if (dz) begin
            quotient    <= '1;
            remainder   <= dvd_raw;
            div_by_zero <= 1'b1;
          end else begin
            quotient    <= q_fix;
            remainder   <= r_fix;
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = RUN;
      RUN:     if (cnt == '0) next_state = FIX;
      FIX:     next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs.
  always_comb begin
    busy      = (state != IDLE) || done_q;
    done      = done_q;
    dbg_state = state;
  end

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;
  import div_pkg::*;

  localparam int N   = 4;
  localparam int LAT = N + 2;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         is_signed;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;
  div_state_e   dbg_state;

  always #5 clk = ~clk;

  seq_divider #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .dbg_state   (dbg_state)
  );

  // ---------------- scoreboard ----------------
  // Entry layout: {quotient, remainder, div_by_zero}
  logic [2*N:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic         is_s;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dz;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Reference model: truncating division, remainder follows the dividend.
  function automatic logic [2*N:0] model(input logic is_s, input logic [N-1:0] a,
                                         input logic [N-1:0] b);
    int sa, sb, qi, ri;
    if (b == '0) return {{N{1'b1}}, a, 1'b1};
    if (is_s) begin
      sa = int'($signed(a));
      sb = int'($signed(b));
    end else begin
      sa = int'(a);
      sb = int'(b);
    end
    qi = sa / sb;
    ri = sa % sb;
    return {qi[N-1:0], ri[N-1:0], 1'b0};
  endfunction

  // ---------------- driver ----------------
  // Drives one operation, optionally pulsing start with junk operands during
  // cycles 2 and 6, then checks latency, pulse width and results.
  task automatic run_op(input logic is_s, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [2*N:0] req, input bit inject, input string tag);
    int cyc;
    bit seen;
    logic [2*N:0] exp_v;
    @(negedge clk);
    start     = 1'b1;
    is_signed = is_s;
    dividend  = a;
    divisor   = b;
    exp_q.push_back(req);
    @(posedge clk);
    #1;
    start     = 1'b0;
    is_signed = 1'($urandom_range(0, 1));
    dividend  = N'($urandom_range(0, 15));
    divisor   = N'($urandom_range(0, 15));
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 20) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (inject && (cyc == 2 || cyc == 6)) begin
        start    = 1'b1;
        dividend = N'($urandom_range(0, 15));
        divisor  = N'($urandom_range(0, 15));
      end else begin
        start = 1'b0;
      end
      if (done) seen = 1'b1;
    end
    check({tag, " latency"}, 32'(cyc), 32'(LAT));
    check({tag, " busy@done"}, 32'(busy), 32'd1);
    exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check({tag, " result"}, 32'({quotient, remainder, div_by_zero}), 32'(exp_v));
    @(negedge clk);
    start = 1'b0;
    check({tag, " done width"}, 32'(done), 32'd0);
    check({tag, " busy after"}, 32'(busy), 32'd0);
    check({tag, " hold"}, 32'({quotient, remainder, div_by_zero}), 32'(exp_v));
  endtask

  // ---------------- stimulus ----------------
  vec_t vecs[11];

  initial begin
    int late_done;
    logic         rs;
    logic [N-1:0] ra, rb;

    vecs[0]  = '{1'b0, 4'b1101, 4'b0011, 4'b0100, 4'b0001, 1'b0};
    vecs[1]  = '{1'b1, 4'b1001, 4'b0010, 4'b1101, 4'b1111, 1'b0};
    vecs[2]  = '{1'b1, 4'b0111, 4'b1110, 4'b1101, 4'b0001, 1'b0};
    vecs[3]  = '{1'b0, 4'b1001, 4'b0000, 4'b1111, 4'b1001, 1'b1};
    vecs[4]  = '{1'b1, 4'b1000, 4'b1111, 4'b1000, 4'b0000, 1'b0};
    vecs[5]  = '{1'b0, 4'b1111, 4'b0100, 4'b0011, 4'b0011, 1'b0};
    vecs[6]  = '{1'b1, 4'b1111, 4'b0001, 4'b1111, 4'b0000, 1'b0};
    vecs[7]  = '{1'b1, 4'b0101, 4'b0000, 4'b1111, 4'b0101, 1'b1};
    vecs[8]  = '{1'b0, 4'b0010, 4'b0111, 4'b0000, 4'b0010, 1'b0};
    vecs[9]  = '{1'b1, 4'b1001, 4'b0011, 4'b1110, 4'b1111, 1'b0};
    vecs[10] = '{1'b0, 4'b1111, 4'b1111, 4'b0001, 4'b0000, 1'b0};

    rst       = 1'b1;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset outputs", 32'({quotient, remainder, div_by_zero}), 32'd0);
    check("reset state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b0;
    @(negedge clk);
    check("idle busy", 32'(busy), 32'd0);

    // Directed table
    foreach (vecs[i])
      run_op(vecs[i].is_s, vecs[i].a, vecs[i].b,
             {vecs[i].q, vecs[i].r, vecs[i].dz}, 1'b0, $sformatf("vec%0d", i));

    // Random operations against the model
    for (int k = 0; k < 20; k++) begin
      rs = 1'($urandom_range(0, 1));
      ra = N'($urandom_range(0, 15));
      rb = N'($urandom_range(0, 15));
      run_op(rs, ra, rb, model(rs, ra, rb), 1'b0, $sformatf("rnd%0d", k));
    end

    // start pulses at cycles 2 and 6 must be ignored
    run_op(1'b0, 4'b1101, 4'b0011, {4'b0100, 4'b0001, 1'b0}, 1'b1, "ignore start");

    // Leave nonzero results and the flag set before the reset test
    run_op(1'b0, 4'b1001, 4'b0000, {4'b1111, 4'b1001, 1'b1}, 1'b0, "pre-reset dz");

    // Reset mid-operation: outputs clear before the next edge
    @(negedge clk);
    start     = 1'b1;
    is_signed = 1'b0;
    dividend  = 4'b1011;
    divisor   = 4'b0010;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid rst busy", 32'(busy), 32'd0);
    check("mid rst done", 32'(done), 32'd0);
    check("mid rst outputs", 32'({quotient, remainder, div_by_zero}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    late_done = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done || busy) late_done++;
    end
    check("no done after rst", 32'(late_done), 32'd0);

    run_op(1'b0, 4'b1111, 4'b0100, {4'b0011, 4'b0011, 1'b0}, 1'b0, "post-reset");

    check("queue empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
